im2_intctl: RTL and testbench

- Multi-source Z80 IM2 interrupt controller; the CPU-facing responder side of the INT/INTA/RETI protocol.
- Collects request pulses from peripherals, drives n_int toward the CPU, and supplies a per-source vector byte during the interrupt acknowledge cycle.
- Decodes RETI (ED 4D) from opcode fetches to retire the in-service level.
- Sits on cpu_bus beside the CPU controller; its d_out/d_out_active feed the same data-bus mux.

---
 rtl/im2_intctl_pkg.sv | 17 +
 rtl/cpu_bus.sv | 11 +
 rtl/im2_intctl_prio_enc.sv | 20 ++
 rtl/im2_intctl.sv | 135 +++++++++++++
 tb/tb_im2_intctl.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/im2_intctl_pkg.sv
// Shared opcodes, RETI decoder state type and vector-byte helper for im2_intctl.
package im2_intctl_pkg;

  localparam logic [7:0] OPC_RETI_PREFIX = 8'hED;
  localparam logic [7:0] OPC_RETI        = 8'h4D;
  localparam logic [7:0] SPURIOUS_OR     = 8'hFE;

  typedef enum logic [0:0] {
    RETI_IDLE,
    RETI_GOT_ED
  } reti_state_t;

  function automatic logic [7:0] vec_byte(input logic [7:0] base, input logic [7:0] idx);
    return base | (idx << 1);
  endfunction

endpackage

// File: rtl/cpu_bus.sv
// Z80-side bus signals shared by the CPU controller and bus responders.
interface cpu_bus;
  logic [15:0] a;
  logic [7:0]  d;
  logic        mreq;
  logic        iorq;
  logic        rd;
  logic        m1;

  modport resp (input a, d, mreq, iorq, rd, m1);
endinterface

// File: rtl/im2_intctl_prio_enc.sv
// Lowest-index-first priority encoder: index of the lowest set bit plus valid flag.
module im2_prio_enc #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  bits_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bits_i[i]) idx_o = IW'(i);
    end
  end

  assign valid_o = |bits_i;

endmodule

// File: rtl/im2_intctl.sv
// Z80 IM2 interrupt controller: request latching, INT/INTA vector supply, RETI retire.
// Nesting and RETI decode are built only when IM2_INTCTL_RETI_EN is defined.
module im2_intctl
  import im2_intctl_pkg::*;
#(
  parameter int         NSRC        = 4,
  parameter logic [7:0] VECTOR_BASE = 8'hF0
) (
  input  logic            clk28,
  input  logic            rst,
  cpu_bus.resp            bus,
  input  logic            clkcpu_ck,
  input  logic [NSRC-1:0] req,
  input  logic [NSRC-1:0] mask,
  output logic            n_int,
  output logic [7:0]      d_out,
  output logic            d_out_active,
  output logic [NSRC-1:0] in_service
);

  localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic            inta, inta_q, inta_start, inta_end;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] svc_q, svc_set;
  logic [NSRC-1:0] allow, eligible, win_onehot;
  logic [IW-1:0]   win_idx, win_q, svc_idx;
  logic            win_valid, svc_valid;
  logic            ack_valid_q, n_int_q;
  logic [7:0]      d_out_q;
  logic            unused_bus_a;

  assign unused_bus_a = ^bus.a;

  assign inta       = bus.iorq & bus.m1;
  assign inta_start = inta & ~inta_q;
  assign inta_end   = ~inta & inta_q;

  im2_prio_enc #(.N(NSRC), .IW(IW)) u_win_enc (
    .bits_i  (eligible),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  im2_prio_enc #(.N(NSRC), .IW(IW)) u_svc_enc (
    .bits_i  (svc_q),
    .idx_o   (svc_idx),
    .valid_o (svc_valid)
  );

  // Only levels strictly above the highest in-service level may interrupt.
  always_comb begin
    allow      = '0;
    win_onehot = '0;
    for (int i = 0; i < NSRC; i++) begin
      allow[i]      = !svc_valid || (IW'(i) < svc_idx);
      win_onehot[i] = (win_q == IW'(i));
    end
  end

  assign eligible  = pending_q & ~mask & allow;
  assign svc_set   = (inta_end && ack_valid_q) ? win_onehot : '0;
  // A request landing on the clearing edge survives the clear.
  assign pending_d = (pending_q & ~svc_set) | req;

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      inta_q      <= 1'b0;
      pending_q   <= '0;
      win_q       <= '0;
      ack_valid_q <= 1'b0;
      n_int_q     <= 1'b1;
      d_out_q     <= VECTOR_BASE;
    end else begin
      inta_q    <= inta;
      pending_q <= pending_d;
      if (clkcpu_ck) n_int_q <= ~|eligible;
      if (inta_start) begin
        ack_valid_q <= win_valid;
        if (win_valid) begin
          win_q   <= win_idx;
          d_out_q <= vec_byte(VECTOR_BASE, 8'(win_idx));
        end else begin
          d_out_q <= VECTOR_BASE | SPURIOUS_OR;
        end
      end
    end
  end

`ifdef IM2_INTCTL_RETI_EN
  reti_state_t     reti_q;
  logic            fetch, fetch_q, fetch_done, retire;
  logic [7:0]      opc_q;
  logic [NSRC-1:0] svc_onehot, svc_clr;

  assign fetch      = bus.m1 & bus.mreq & bus.rd & ~bus.iorq;
  assign fetch_done = fetch_q & ~fetch;
  assign retire     = fetch_done && (reti_q == RETI_GOT_ED) && (opc_q == OPC_RETI);

  always_comb begin
    svc_onehot = '0;
    for (int i = 0; i < NSRC; i++) svc_onehot[i] = svc_valid && (svc_idx == IW'(i));
  end

  assign svc_clr = retire ? svc_onehot : '0;

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      reti_q  <= RETI_IDLE;
      fetch_q <= 1'b0;
      opc_q   <= '0;
      svc_q   <= '0;
    end else begin
      fetch_q <= fetch;
      if (fetch) opc_q <= bus.d;
      svc_q <= (svc_q & ~svc_clr) | svc_set;
      if (fetch_done) begin
        if (opc_q == OPC_RETI_PREFIX) reti_q <= RETI_GOT_ED;
        else                          reti_q <= RETI_IDLE;
      end
    end
  end
`else
  logic unused_fetch_bus;

  assign unused_fetch_bus = ^{bus.d, bus.mreq, bus.rd, svc_set};
  assign svc_q            = '0;
`endif

  assign n_int        = n_int_q;
  assign d_out        = d_out_q;
  assign d_out_active = inta & ~rst;
  assign in_service   = svc_q;

endmodule

// File: tb/tb_im2_intctl.sv
// Self-checking bench for im2_intctl: vector table plus multi-cycle INTA/RETI sequences.
module tb_im2_intctl;

`ifdef IM2_INTCTL_RETI_EN
  localparam bit RETI = 1'b1;
`else
  localparam bit RETI = 1'b0;
`endif

  logic       clk28 = 1'b0;
  logic       rst = 1'b1;
  logic       clkcpu_ck = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] mask = '0;
  logic       n_int, d_out_active;
  logic [7:0] d_out;
  logic [3:0] in_service;

  cpu_bus bus_if();

  im2_intctl #(.NSRC(4), .VECTOR_BASE(8'hF0)) dut (
    .clk28        (clk28),
    .rst          (rst),
    .bus          (bus_if),
    .clkcpu_ck    (clkcpu_ck),
    .req          (req),
    .mask         (mask),
    .n_int        (n_int),
    .d_out        (d_out),
    .d_out_active (d_out_active),
    .in_service   (in_service)
  );

  always #5 clk28 = ~clk28;

  // CPU clock edge strobe: one clk28 out of every four.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk28);
      cnt++;
      clkcpu_ck = (cnt % 4 == 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got timeout required completion");
    $fatal(1);
  end

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      name;
    logic [7:0] vec;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [3:0] req;
    logic [3:0] mask;
    logic [7:0] vec;
    logic [3:0] svc;
  } vec_t;
  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk28);
  endtask

  task automatic pulse(input logic [3:0] r);
    @(negedge clk28);
    req = r;
    @(negedge clk28);
    req = '0;
  endtask

  // One acknowledge cycle; req_at_end is driven on the edge that retires the ack.
  task automatic inta(input string name, input logic [7:0] expv, input logic [3:0] req_at_end);
    sb_t e;
    e.name = name;
    e.vec  = expv;
    @(negedge clk28);
    bus_if.iorq = 1'b1;
    bus_if.m1   = 1'b1;
    sb_q.push_back(e);
    @(negedge clk28);
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_sb: got empty queue required one entry", name);
    end else begin
      e = sb_q.pop_front();
      check({e.name, "_vec"}, d_out, e.vec);
    end
    check({name, "_act"}, d_out_active, 1);
    idle(2);
    bus_if.iorq = 1'b0;
    bus_if.m1   = 1'b0;
    req         = req_at_end;
    @(negedge clk28);
    req = '0;
    check({name, "_act_off"}, d_out_active, 0);
    idle(1);
  endtask

  task automatic fetch(input logic [7:0] b, input logic is_m1);
    @(negedge clk28);
    bus_if.m1   = is_m1;
    bus_if.mreq = 1'b1;
    bus_if.rd   = 1'b1;
    bus_if.d    = b;
    idle(2);
    bus_if.m1   = 1'b0;
    bus_if.mreq = 1'b0;
    bus_if.rd   = 1'b0;
    bus_if.d    = 8'h00;
    idle(2);
  endtask

  task automatic reti();
    fetch(8'hED, 1'b1);
    fetch(8'h4D, 1'b1);
  endtask

  initial begin
    bus_if.a    = 16'h0000;
    bus_if.d    = 8'h00;
    bus_if.mreq = 1'b0;
    bus_if.iorq = 1'b0;
    bus_if.rd   = 1'b0;
    bus_if.m1   = 1'b0;

    tbl[0] = '{req: 4'b0100, mask: 4'b0000, vec: 8'hF4, svc: 4'b0100};
    tbl[1] = '{req: 4'b0001, mask: 4'b1000, vec: 8'hF0, svc: 4'b0001};
    tbl[2] = '{req: 4'b1000, mask: 4'b0111, vec: 8'hF6, svc: 4'b1000};
    tbl[3] = '{req: 4'b0010, mask: 4'b0101, vec: 8'hF2, svc: 4'b0010};

    idle(5);
    check("rst_nint", n_int, 1);
    check("rst_act", d_out_active, 0);
    check("rst_svc", in_service, 0);
    check("rst_dout", d_out, 8'hF0);
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 4; i++) begin
      mask = tbl[i].mask;
      pulse(tbl[i].req);
      idle(6);
      check("tbl_nint_low", n_int, 0);
      inta("tbl", tbl[i].vec, 4'b0000);
      check("tbl_svc", in_service, RETI ? tbl[i].svc : 4'b0000);
      idle(6);
      check("tbl_nint_high", n_int, 1);
      reti();
      check("tbl_svc_clr", in_service, 0);
    end
    mask = '0;

    // Two simultaneous requests: index 1 wins, index 3 waits behind it.
    pulse(4'b1010);
    idle(6);
    check("prio_nint", n_int, 0);
    inta("prio1", 8'hF2, 4'b0000);
    check("prio_svc1", in_service, RETI ? 4'b0010 : 4'b0000);
    idle(6);
    check("prio_blocked", n_int, RETI ? 1 : 0);
    reti();
    idle(6);
    check("prio_nint2", n_int, 0);
    inta("prio2", 8'hF6, 4'b0000);
    check("prio_svc2", in_service, RETI ? 4'b1000 : 4'b0000);
    reti();
    idle(6);
    check("prio_done", n_int, 1);

    // Nesting: level 1 in service, level 2 blocked, level 0 nests.
    pulse(4'b0010);
    idle(6);
    inta("nest_a", 8'hF2, 4'b0000);
    check("nest_svc_a", in_service, RETI ? 4'b0010 : 4'b0000);
    pulse(4'b0100);
    idle(6);
    check("nest_lower_blk", n_int, RETI ? 1 : 0);
    pulse(4'b0001);
    idle(6);
    check("nest_hi_nint", n_int, 0);
    inta("nest_b", 8'hF0, 4'b0000);
    check("nest_svc_b", in_service, RETI ? 4'b0011 : 4'b0000);
    reti();
    check("nest_reti1", in_service, RETI ? 4'b0010 : 4'b0000);
    idle(6);
    check("nest_still_blk", n_int, RETI ? 1 : 0);
    reti();
    check("nest_reti2", in_service, 0);
    idle(6);
    check("nest_pend2", n_int, 0);
    inta("nest_c", 8'hF4, 4'b0000);
    reti();
    idle(6);
    check("nest_done", n_int, 1);

    // RETI decode negatives.
    pulse(4'b1000);
    idle(6);
    inta("dec_a", 8'hF6, 4'b0000);
    fetch(8'hED, 1'b1);
    fetch(8'h00, 1'b1);
    fetch(8'h4D, 1'b1);
    check("dec_ed00", in_service, RETI ? 4'b1000 : 4'b0000);
    fetch(8'hED, 1'b1);
    fetch(8'hED, 1'b1);
    fetch(8'h4D, 1'b1);
    check("dec_eded", in_service, 0);
    pulse(4'b1000);
    idle(6);
    inta("dec_b", 8'hF6, 4'b0000);
    fetch(8'hED, 1'b0);
    fetch(8'h4D, 1'b1);
    check("dec_nonm1", in_service, RETI ? 4'b1000 : 4'b0000);
    reti();
    check("dec_clean", in_service, 0);

    // Repeated request while pending merges into a single ack.
    pulse(4'b0100);
    pulse(4'b0100);
    idle(6);
    inta("merge", 8'hF4, 4'b0000);
    reti();
    idle(6);
    check("merge_single", n_int, 1);

    // Request arriving on the clearing edge keeps pending set.
    pulse(4'b0100);
    idle(6);
    inta("reqwin", 8'hF4, 4'b0100);
    check("reqwin_svc", in_service, RETI ? 4'b0100 : 4'b0000);
    idle(6);
    check("reqwin_nint", n_int, RETI ? 1 : 0);
    reti();
    idle(6);
    check("reqwin_repend", n_int, 0);
    inta("reqwin2", 8'hF4, 4'b0000);
    reti();
    idle(6);
    check("reqwin_done", n_int, 1);

    // Masked request, spurious ack, then unmask.
    mask = 4'b0001;
    pulse(4'b0001);
    idle(6);
    check("mask_nint", n_int, 1);
    inta("spur", 8'hFE, 4'b0000);
    check("spur_svc", in_service, 0);
    mask = 4'b0000;
    idle(6);
    check("unmask_nint", n_int, 0);
    inta("unmask", 8'hF0, 4'b0000);
    reti();
    idle(6);
    check("unmask_done", n_int, 1);

    // Reset in the middle of an acknowledge.
    pulse(4'b0010);
    idle(6);
    @(negedge clk28);
    bus_if.iorq = 1'b1;
    bus_if.m1   = 1'b1;
    @(negedge clk28);
    check("midrst_vec", d_out, 8'hF2);
    check("midrst_act_on", d_out_active, 1);
    rst = 1'b1;
    #1;
    check("midrst_act_off", d_out_active, 0);
    check("midrst_dout", d_out, 8'hF0);
    check("midrst_nint", n_int, 1);
    bus_if.iorq = 1'b0;
    bus_if.m1   = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(6);
    check("midrst_pend_gone", n_int, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
